// File: rtl/band_energy_accum.sv
// Per-band energy accumulator for a 16-band filter bank: sums shifted magnitudes
// over FRAME_LEN enabled samples, then streams the 16 band energies out.
module band_energy_accum #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned SHIFT     = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clk_enable,
  input  logic [591:0] band_in,
  input  logic         ovr_clear,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [31:0]  out_data,
  output logic [3:0]   out_chan,
  output logic         out_last,
  output logic         overrun
);

  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        overrun_q, overrun_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] acc_q  [16];
  logic [31:0] snap_q [16];
  logic [23:0] shmag  [16];
  logic [31:0] accsum [16];
  logic        frame_end, capture, drop;

  assign frame_end = clk_enable && (cnt_q == CNT_LAST);

  for (genvar k = 0; k < 16; k++) begin : g_band
    logic [36:0] b;
    logic [35:0] mag;
    logic [32:0] sum;

    assign b = band_in[37*k +: 37];

    // Negative values fold into 36 bits except -2^36, which clamps to full scale.
    always_comb begin
      if (!b[36])                mag = b[35:0];
      else if (b[35:0] == '0)    mag = '1;
      else                       mag = -b[35:0];
    end

    assign shmag[k]  = 24'(mag >> SHIFT);
    assign sum       = {1'b0, acc_q[k]} + 33'(shmag[k]);
    assign accsum[k] = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      if (clk_enable) begin
        cnt_q <= frame_end ? '0 : cnt_q + 1'b1;
        for (int unsigned k = 0; k < 16; k++)
          acc_q[k] <= frame_end ? '0 : accsum[k];
      end
      if (capture) begin
        for (int unsigned k = 0; k < 16; k++)
          snap_q[k] <= accsum[k];
      end
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    drop      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_chan  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_end) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = snap_q[idx_q];
        out_chan  = idx_q;
        out_last  = (idx_q == 4'd15);
        if (out_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = IDLE;
        end
        // A frame ending on the final transfer is streamed back-to-back; otherwise dropped.
        if (frame_end) begin
          if (out_ready && idx_q == 4'd15) begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    overrun_d = drop ? 1'b1 : (ovr_clear ? 1'b0 : overrun_q);
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_band_energy_accum.sv
// Directed bench for band_energy_accum: frame sums, sign/saturation handling,
// backpressure with overrun, back-to-back frames and mid-stream reset.
module tb_band_energy_accum;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clk_enable = 1'b0;
  logic [591:0] band_in = '0;
  logic         ovr_clear = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid, out_last, overrun;
  logic [31:0]  out_data;
  logic [3:0]   out_chan;

  logic         sat_reset = 1'b1;
  logic         sat_ready = 1'b1;
  logic         sat_valid, sat_last, sat_overrun;
  logic [31:0]  sat_data;
  logic [3:0]   sat_chan;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_w [16];

  band_energy_accum #(.FRAME_LEN(64), .SHIFT(12)) dut (
    .clock(clock), .reset(reset), .clk_enable(clk_enable), .band_in(band_in),
    .ovr_clear(ovr_clear), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last), .overrun(overrun)
  );

  band_energy_accum #(.FRAME_LEN(512), .SHIFT(12)) dut_sat (
    .clock(clock), .reset(sat_reset), .clk_enable(clk_enable), .band_in(band_in),
    .ovr_clear(ovr_clear), .out_ready(sat_ready), .out_valid(sat_valid),
    .out_data(sat_data), .out_chan(sat_chan), .out_last(sat_last), .overrun(sat_overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_all(input longint v);
    for (int k = 0; k < 16; k++) band_in[37*k +: 37] = v[36:0];
  endtask

  task automatic set_ramp(input longint unit);
    longint v;
    for (int k = 0; k < 16; k++) begin
      v = unit * (k + 1);
      band_in[37*k +: 37] = v[36:0];
    end
  endtask

  task automatic exp_ramp(input int unsigned scale);
    for (int k = 0; k < 16; k++) exp_w[k] = 32'(scale * (k + 1));
  endtask

  task automatic exp_const(input logic [31:0] v);
    for (int k = 0; k < 16; k++) exp_w[k] = v;
  endtask

  // Expects out_valid now and out_ready held high: 16 in-order words, then idle.
  task automatic check_stream(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp_w[i]);
      chk({tag, "_chan"}, out_chan, i);
      chk({tag, "_last"}, out_last, (i == 15));
      tick();
    end
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overrun", overrun, 0);

    // Ramp input, continuous enable and ready.
    do_reset();
    set_ramp(4096);
    clk_enable = 1'b1;
    out_ready  = 1'b1;
    repeat (63) tick();
    chk("ramp_early", out_valid, 0);
    tick();
    exp_ramp(64);
    check_stream("ramp");
    chk("ramp_ovr", overrun, 0);

    // Negative input with enable toggling: 64 enables over 128 cycles.
    do_reset();
    set_all(-8192);
    for (int i = 0; i < 63; i++) begin
      clk_enable = 1'b1; tick();
      clk_enable = 1'b0; tick();
    end
    chk("toggle_early", out_valid, 0);
    clk_enable = 1'b1; tick();
    clk_enable = 1'b0;
    exp_const(32'd128);
    check_stream("toggle");

    // Most negative input: 64-frame sum on main DUT, 32-bit saturation on 512-frame DUT.
    reset = 1'b1; sat_reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0; sat_reset = 1'b0;
    set_all(-(64'sd1 <<< 36));
    clk_enable = 1'b1;
    out_ready  = 1'b1;
    repeat (64) tick();
    exp_const(32'd1073741760);
    check_stream("minneg");
    repeat (432) tick();
    for (int i = 0; i < 16; i++) begin
      chk("sat_valid", sat_valid, 1);
      chk("sat_data", sat_data, 32'hFFFF_FFFF);
      chk("sat_chan", sat_chan, i);
      tick();
    end
    chk("sat_idle", sat_valid, 0);
    sat_reset = 1'b1;

    // Backpressure: second frame is dropped, first frame delivered intact.
    do_reset();
    set_ramp(4096);
    clk_enable = 1'b1;
    out_ready  = 1'b0;
    repeat (64) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_chan", out_chan, 0);
    chk("bp_data", out_data, 64);
    repeat (63) tick();
    chk("bp_hold_chan", out_chan, 0);
    chk("bp_hold_data", out_data, 64);
    chk("bp_ovr_pre", overrun, 0);
    tick();
    chk("bp_ovr_set", overrun, 1);
    tick(); tick();
    clk_enable = 1'b0;
    out_ready  = 1'b1;
    exp_ramp(64);
    check_stream("bp");
    chk("bp_ovr_sticky", overrun, 1);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    chk("bp_ovr_clear", overrun, 0);

    // Sparse ready: final transfer lands on the next frame end.
    do_reset();
    set_ramp(4096);
    clk_enable = 1'b1;
    for (int t = 1; t <= 128; t++) begin
      out_ready = (t % 4 == 0) && (t >= 68);
      tick();
      if (t == 64) begin
        chk("b2b_valid", out_valid, 1);
        set_ramp(8192);
      end
      if (t == 127) chk("b2b_idx15", out_chan, 15);
    end
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_chan0", out_chan, 0);
    chk("b2b_data0", out_data, 128);
    chk("b2b_ovr", overrun, 0);
    out_ready = 1'b1;
    exp_ramp(128);
    check_stream("b2b");
    chk("b2b_ovr_end", overrun, 0);

    // Reset in the middle of a stream.
    do_reset();
    set_ramp(4096);
    clk_enable = 1'b1;
    out_ready  = 1'b1;
    repeat (64) tick();
    chk("mid_valid", out_valid, 1);
    repeat (7) tick();
    chk("mid_idx7", out_chan, 7);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_chan", out_chan, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (63) tick();
    chk("mid_no_partial", out_valid, 0);
    tick();
    exp_ramp(64);
    check_stream("mid");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
